strobe_pad_sequencer: RTL and testbench

//  Multi-lane bidirectional strobe pad controller; generalises the single-lane tristate h/l pad driver.

---
 rtl/strobe_pad_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_strobe_pad_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_pad_sequencer.sv
// strobe_pad_sequencer: multi-lane strobe pad driver that frames each write burst with
// preamble / toggling strobe / postamble / turnaround, and counts returned strobe edges
// per lane while idle when the pads are bidirectional.
module strobe_pad_sequencer #(
  parameter int unsigned LANES        = 2,
  parameter int unsigned DIFFERENTIAL = 1,
  parameter int unsigned BIDIR        = 1,
  parameter int unsigned PREAMBLE     = 1,
  parameter int unsigned POSTAMBLE    = 1,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [LEN_W-1:0]         tx_len,
  input  logic [LANES-1:0]         tx_lane_en,
  output logic                     busy,
  inout  wire  [LANES-1:0]         pad_h,
  inout  wire  [LANES-1:0]         pad_l,
  input  logic                     rx_clr,
  output logic [LANES*CNT_W-1:0]   rx_edge_cnt
);

  // Phase counter must hold the longest of preamble, postamble and burst length
  localparam int unsigned PH_W = (LEN_W > 4) ? LEN_W : 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_BURST = 3'd2,
    S_POST  = 3'd3,
    S_TURN  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [PH_W-1:0]   r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [LANES-1:0]  r_lane, w_lane_nxt;
  logic [LANES-1:0]  r_oe, w_oe_nxt;
  logic              r_hval, w_hval_nxt;
  logic              r_tx_ready;
  logic              r_busy;
  logic              w_accept;

  assign w_accept = tx_valid & r_tx_ready;
  assign tx_ready = r_tx_ready;
  assign busy     = r_busy;

  // Next-state, phase count and next-cycle pad drive for the burst sequence
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_lane_nxt  = r_lane;
    w_oe_nxt    = '0;
    w_hval_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_PRE;
          w_cnt_nxt   = PH_W'(PREAMBLE - 1);
          w_len_nxt   = tx_len;
          w_lane_nxt  = tx_lane_en;
          w_oe_nxt    = tx_lane_en;
        end
      end
      S_PRE: begin
        w_oe_nxt = r_lane;
        if (r_cnt == '0) begin
          if (r_len != '0) begin
            w_state_nxt = S_BURST;
            w_cnt_nxt   = PH_W'(r_len) - PH_W'(1);
            w_hval_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_POST;
            w_cnt_nxt   = PH_W'(POSTAMBLE - 1);
          end
        end else begin
          w_cnt_nxt = r_cnt - PH_W'(1);
        end
      end
      S_BURST: begin
        w_oe_nxt = r_lane;
        if (r_cnt == '0) begin
          w_state_nxt = S_POST;
          w_cnt_nxt   = PH_W'(POSTAMBLE - 1);
        end else begin
          w_cnt_nxt  = r_cnt - PH_W'(1);
          w_hval_nxt = ~r_hval;
        end
      end
      S_POST: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_TURN;
        end else begin
          w_cnt_nxt = r_cnt - PH_W'(1);
          w_oe_nxt  = r_lane;
        end
      end
      S_TURN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, phase counter, latched burst request and registered pad drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_lane     <= '0;
      r_oe       <= '0;
      r_hval     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_len      <= w_len_nxt;
      r_lane     <= w_lane_nxt;
      r_oe       <= w_oe_nxt;
      r_hval     <= w_hval_nxt;
      r_tx_ready <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Pad drivers: undriven lanes float when bidirectional, otherwise park h=0 / l=1
  for (genvar gi = 0; gi < LANES; gi++) begin : g_pad
    if (BIDIR != 0) begin : g_bidir
      assign pad_h[gi] = r_oe[gi] ? r_hval : 1'bz;
    end else begin : g_park
      assign pad_h[gi] = r_oe[gi] & r_hval;
    end
    if (DIFFERENTIAL == 0) begin : g_se
      assign pad_l[gi] = 1'bz;
    end else if (BIDIR != 0) begin : g_diff_bidir
      assign pad_l[gi] = r_oe[gi] ? ~r_hval : 1'bz;
    end else begin : g_diff_park
      assign pad_l[gi] = ~(r_oe[gi] & r_hval);
    end
  end

  if (BIDIR != 0) begin : g_rx
    logic [LANES-1:0] r_s1, r_s2, r_s3;
    logic [LANES-1:0] w_sense;
    logic [LANES-1:0] w_cnt_en;
    logic [CNT_W-1:0] r_rx_cnt [LANES];

    // Sense bit; a differential pair with equal legs keeps the last valid level
    for (genvar gi = 0; gi < LANES; gi++) begin : g_sense
      if (DIFFERENTIAL != 0) begin : g_d
        assign w_sense[gi] = (pad_h[gi] != pad_l[gi]) ? pad_h[gi] : r_s1[gi];
      end else begin : g_s
        assign w_sense[gi] = pad_h[gi];
      end
      assign rx_edge_cnt[gi*CNT_W +: CNT_W] = r_rx_cnt[gi];
    end

    // Only count returned edges while idle and not driving the lane ourselves
    assign w_cnt_en = (r_state == S_IDLE) ? (r_s2 & ~r_s3 & ~r_oe) : '0;

    // Two-flop synchroniser plus previous-value flop for rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1 <= '0;
        r_s2 <= '0;
        r_s3 <= '0;
      end else begin
        r_s1 <= w_sense;
        r_s2 <= r_s1;
        r_s3 <= r_s2;
      end
    end

    // Per-lane saturating edge counters; clear wins over a coincident edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LANES; i++) r_rx_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if (rx_clr) begin
            r_rx_cnt[i] <= '0;
          end else if (w_cnt_en[i] && (r_rx_cnt[i] != {CNT_W{1'b1}})) begin
            r_rx_cnt[i] <= r_rx_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end else begin : g_no_rx
    wire w_unused_rx = rx_clr ^ (^pad_l);
    assign rx_edge_cnt = '0;
  end

endmodule

// File: tb/tb_strobe_pad_sequencer.sv
// Testbench for strobe_pad_sequencer: three instances (default, 3-bit rx counters,
// output-only single-ended) share the burst stimulus; pads carry pull-ups so a
// released pad reads as 1 on both legs.
module tb_strobe_pad_sequencer;

  localparam int PRE  = 1;
  localparam int POST = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_valid;
  logic [7:0]  tx_len;
  logic [1:0]  tx_lane_en;
  logic        rx_clr;

  logic        m_ready, m_busy, c_ready, c_busy, o_ready, o_busy;
  logic [15:0] m_cnt, o_cnt;
  logic [5:0]  c_cnt;
  wire  [1:0]  m_h, m_l, c_h, c_l, o_h, o_l;

  logic [1:0]  m_xe, m_xh, c_xe, c_xh;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_pads
    pullup (m_h[g]);
    pullup (m_l[g]);
    pullup (c_h[g]);
    pullup (c_l[g]);
    pullup (o_h[g]);
    pullup (o_l[g]);
    assign m_h[g] = m_xe[g] ? m_xh[g]  : 1'bz;
    assign m_l[g] = m_xe[g] ? ~m_xh[g] : 1'bz;
    assign c_h[g] = c_xe[g] ? c_xh[g]  : 1'bz;
    assign c_l[g] = c_xe[g] ? ~c_xh[g] : 1'bz;
  end

  strobe_pad_sequencer u_main (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(m_ready),
    .tx_len(tx_len), .tx_lane_en(tx_lane_en), .busy(m_busy),
    .pad_h(m_h), .pad_l(m_l), .rx_clr(rx_clr), .rx_edge_cnt(m_cnt)
  );

  strobe_pad_sequencer #(.CNT_W(3)) u_c3 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(c_ready),
    .tx_len(tx_len), .tx_lane_en(tx_lane_en), .busy(c_busy),
    .pad_h(c_h), .pad_l(c_l), .rx_clr(rx_clr), .rx_edge_cnt(c_cnt)
  );

  strobe_pad_sequencer #(.BIDIR(0), .DIFFERENTIAL(0)) u_ob (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(o_ready),
    .tx_len(tx_len), .tx_lane_en(tx_lane_en), .busy(o_busy),
    .pad_h(o_h), .pad_l(o_l), .rx_clr(rx_clr), .rx_edge_cnt(o_cnt)
  );

  typedef struct packed {
    logic       busy;
    logic       ready;
    logic [1:0] mh;
    logic [1:0] ml;
    logic [1:0] oh;
    logic [1:0] ol;
  } obs_t;

  typedef struct {
    int         len;
    logic [1:0] en;
    int         lat;
  } vec_t;

  obs_t sb_q[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pads k cycles after the accept edge; a released pad reads 1 via pull-up
  function automatic obs_t model(input int k, input int len, input logic [1:0] en, input int lat);
    obs_t o;
    logic drv, val;
    drv = 1'b0;
    val = 1'b0;
    if (k < lat) begin
      if (k < PRE) begin
        drv = 1'b1;
      end else if (k < PRE + len) begin
        drv = 1'b1;
        val = ((k - PRE) % 2) == 0;
      end else if (k < PRE + len + POST) begin
        drv = 1'b1;
      end
    end
    o.busy  = (k < lat);
    o.ready = (k >= lat);
    for (int i = 0; i < 2; i++) begin
      o.mh[i] = (en[i] && drv) ? val : 1'b1;
      o.ml[i] = (en[i] && drv) ? ~val : 1'b1;
      o.oh[i] = en[i] && drv && val;
      o.ol[i] = 1'b1;
    end
    return o;
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (m_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(m_ready), 32'd1);
  endtask

  // Issue one burst, queue the expected trace, then compare it cycle by cycle
  task automatic run_burst(input int len, input logic [1:0] en, input int lat, input string tag);
    obs_t a, e;
    wait_ready();
    tx_len     = 8'(len);
    tx_lane_en = en;
    tx_valid   = 1'b1;
    for (int k = 0; k <= lat; k++) sb_q.push_back(model(k, len, en, lat));
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      a = {m_busy, m_ready, m_h, m_l, o_h, o_l};
      e = sb_q.pop_front();
      check($sformatf("%s_cyc%0d", tag, k), 32'(a), 32'(e));
    end
  endtask

  // External differential drive: n rising edges on one lane, each level held 2 cycles
  task automatic ext_edges(input bit to_c3, input int lane, input int n);
    if (to_c3) begin c_xh[lane] = 1'b0; c_xe[lane] = 1'b1; end
    else       begin m_xh[lane] = 1'b0; m_xe[lane] = 1'b1; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (to_c3) c_xh[lane] = 1'b1; else m_xh[lane] = 1'b1;
      repeat (2) @(negedge clk);
      if (to_c3) c_xh[lane] = 1'b0; else m_xh[lane] = 1'b0;
      repeat (2) @(negedge clk);
    end
    if (to_c3) c_xe[lane] = 1'b0; else m_xe[lane] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{len: 3,   en: 2'b11, lat: 6};
    vecs[1] = '{len: 0,   en: 2'b01, lat: 3};
    vecs[2] = '{len: 2,   en: 2'b11, lat: 5};
    vecs[3] = '{len: 1,   en: 2'b10, lat: 4};
    vecs[4] = '{len: 0,   en: 2'b00, lat: 3};
    vecs[5] = '{len: 255, en: 2'b11, lat: 258};
    vecs[6] = '{len: 4,   en: 2'b01, lat: 7};

    rst_n = 1'b0; tx_valid = 1'b0; tx_len = '0; tx_lane_en = '0; rx_clr = 1'b0;
    m_xe = '0; m_xh = '0; c_xe = '0; c_xh = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(m_ready), 32'd0);
    check("rst_busy",  32'(m_busy),  32'd0);
    check("rst_pads",  32'({m_h, m_l}), 32'h0f);
    check("rst_ob_pads", 32'({o_h, o_l}), 32'h03);
    check("rst_cnt",   32'(m_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(m_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      run_burst(vecs[v].len, vecs[v].en, vecs[v].lat, $sformatf("vec%0d", v));
    end
    check("ob_cnt", 32'(o_cnt), 32'd0);
    check("m_cnt_after_bursts", 32'(m_cnt), 32'd0);

    // Returned edges on lane1 while idle
    ext_edges(1'b0, 1, 5);
    check("rx_lane1_5", 32'(m_cnt), 32'h0500);
    rx_clr = 1'b1;
    @(negedge clk);
    rx_clr = 1'b0;
    check("rx_clr", 32'(m_cnt), 32'd0);

    // Clear held during edges keeps counter at zero
    rx_clr = 1'b1;
    ext_edges(1'b1, 0, 3);
    check("rx_clr_prio", 32'(c_cnt), 32'd0);
    rx_clr = 1'b0;

    // Saturation of 3-bit counter, then own burst leaves it untouched
    ext_edges(1'b1, 1, 10);
    check("rx_sat", 32'(c_cnt), 32'h38);
    run_burst(4, 2'b11, 7, "own_burst");
    repeat (4) @(negedge clk);
    check("rx_sat_hold", 32'(c_cnt), 32'h38);
    check("rx_main_hold", 32'(m_cnt), 32'd0);

    // Reset asserted mid-burst
    wait_ready();
    tx_len = 8'd3; tx_lane_en = 2'b11; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(m_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pads", 32'({m_h, m_l}), 32'h0f);
    check("mid_rst_ob",   32'({o_h, o_l}), 32'h03);
    check("mid_rst_busy", 32'(m_busy), 32'd0);
    check("mid_rst_cnt",  32'(c_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(m_ready), 32'd1);
    run_burst(3, 2'b11, 6, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
